// File: rtl/sd_wr_sector_buf.sv
// Sector staging buffer for the SD SPI block-write path.
// 32-bit words go in, bytes come out MSB first on a one-byte-per-request
// handshake. The data CRC16 (CCITT 0x1021, init 0) is optionally appended
// after every full sector, and sector_done marks the last byte of each sector.
module sd_wr_sector_buf #(
  parameter int AW     = 7,
  parameter bit CRC_EN = 1'b1
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          byte_rd,
  output logic [7:0]    byte_out,
  output logic          byte_vld,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic [15:0]   crc16,
  output logic          sector_done,
  output logic          ovf,
  output logic          unf
);

  localparam int            WORDS     = 2**AW;
  localparam logic [AW+1:0] LAST_BYTE = (AW+2)'(4*WORDS-1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(WORDS);

  typedef enum logic [1:0] {S_DATA, S_CRC_H, S_CRC_L} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] wp_reg, wp_next;
  logic [AW-1:0] rp_reg, rp_next;
  logic [1:0]    bi_reg, bi_next;
  logic [AW+1:0] bcnt_reg, bcnt_next;
  logic [AW:0]   level_reg, level_next;
  logic [15:0]   crc_reg, crc_next;
  logic [7:0]    byte_out_reg, byte_out_next;
  logic          byte_vld_reg, byte_vld_next;
  logic          done_reg, done_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;
  logic          push, pop;

  logic [31:0]   mem [WORDS];
  logic [31:0]   word_q_reg;
  logic [7:0]    word_bytes [4];
  logic [7:0]    cur_byte;

  // One CCITT CRC step over a full byte, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ b[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Split the head word into bytes, index 0 being the most significant.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign word_bytes[gi] = word_q_reg[31-8*gi -: 8];
    end
  endgenerate

  assign cur_byte = word_bytes[bi_reg];

  assign full        = (level_reg == FULL_LVL);
  assign empty       = (level_reg == '0);
  assign level       = level_reg;
  assign byte_out    = byte_out_reg;
  assign byte_vld    = byte_vld_reg;
  assign crc16       = crc_reg;
  assign sector_done = done_reg;
  assign ovf         = ovf_reg;
  assign unf         = unf_reg;

  // Storage: the head word is re-read every cycle at the next read pointer so it is
  // ready one cycle ahead; a write landing on that address is forwarded directly.
  always_ff @(posedge sys_clk) begin
    if (push && !rst) mem[wp_reg] <= wr_data;
    word_q_reg <= (push && (wp_reg == rp_next)) ? wr_data : mem[rp_next];
  end

  // Next-state and datapath control; clr overrides everything at the end.
  always_comb begin
    state_next    = state_reg;
    bi_next       = bi_reg;
    bcnt_next     = bcnt_reg;
    crc_next      = crc_reg;
    byte_out_next = byte_out_reg;
    byte_vld_next = 1'b0;
    done_next     = 1'b0;
    ovf_next      = ovf_reg;
    unf_next      = unf_reg;
    push          = wr_en && !full;
    pop           = 1'b0;

    if (wr_en && full) ovf_next = 1'b1;

    case (state_reg)
      S_DATA: begin
        if (byte_rd) begin
          if (!empty) begin
            byte_out_next = cur_byte;
            byte_vld_next = 1'b1;
            crc_next      = crc_step(crc_reg, cur_byte);
            bi_next       = bi_reg + 2'd1;
            bcnt_next     = bcnt_reg + 1'b1;
            if (bi_reg == 2'd3) pop = 1'b1;
            if (bcnt_reg == LAST_BYTE) begin
              if (CRC_EN) begin
                state_next = S_CRC_H;
              end else begin
                done_next = 1'b1;
                bcnt_next = '0;
                crc_next  = '0;
              end
            end
          end else begin
            unf_next = 1'b1;
          end
        end
      end
      S_CRC_H: begin
        if (byte_rd) begin
          byte_out_next = crc_reg[15:8];
          byte_vld_next = 1'b1;
          state_next    = S_CRC_L;
        end
      end
      S_CRC_L: begin
        if (byte_rd) begin
          byte_out_next = crc_reg[7:0];
          byte_vld_next = 1'b1;
          done_next     = 1'b1;
          crc_next      = '0;
          bcnt_next     = '0;
          state_next    = S_DATA;
        end
      end
      default: state_next = S_DATA;
    endcase

    wp_next    = wp_reg + AW'(push);
    rp_next    = rp_reg + AW'(pop);
    level_next = level_reg + (AW+1)'(push) - (AW+1)'(pop);

    if (clr) begin
      state_next    = S_DATA;
      push          = 1'b0;
      pop           = 1'b0;
      wp_next       = '0;
      rp_next       = '0;
      level_next    = '0;
      bi_next       = '0;
      bcnt_next     = '0;
      crc_next      = '0;
      byte_out_next = '0;
      byte_vld_next = 1'b0;
      done_next     = 1'b0;
      ovf_next      = 1'b0;
      unf_next      = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg    <= S_DATA;
      wp_reg       <= '0;
      rp_reg       <= '0;
      bi_reg       <= '0;
      bcnt_reg     <= '0;
      level_reg    <= '0;
      crc_reg      <= '0;
      byte_out_reg <= '0;
      byte_vld_reg <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wp_reg       <= wp_next;
      rp_reg       <= rp_next;
      bi_reg       <= bi_next;
      bcnt_reg     <= bcnt_next;
      level_reg    <= level_next;
      crc_reg      <= crc_next;
      byte_out_reg <= byte_out_next;
      byte_vld_reg <= byte_vld_next;
      done_reg     <= done_next;
      ovf_reg      <= ovf_next;
      unf_reg      <= unf_next;
    end
  end

endmodule

// File: tb/tb_sd_wr_sector_buf.sv
// Bench for sd_wr_sector_buf: a byte-queue model checked every cycle on the
// CRC-enabled instance, plus directed literal checks on both instances.
module tb_sd_wr_sector_buf;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, byte_rd;
  logic [31:0] wr_data;
  logic [7:0]  byte_out;
  logic        byte_vld, full, empty, sector_done, ovf, unf;
  logic [7:0]  level;
  logic [15:0] crc16;

  logic        wr_en0, byte_rd0;
  logic [31:0] wr_data0;
  logic [7:0]  byte_out0;
  logic        byte_vld0, full0, empty0, sector_done0, ovf0, unf0;
  logic [7:0]  level0;
  logic [15:0] crc16_0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sd_wr_sector_buf #(.AW(7), .CRC_EN(1'b1)) dut (
    .sys_clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .byte_rd(byte_rd), .byte_out(byte_out), .byte_vld(byte_vld), .level(level),
    .full(full), .empty(empty), .crc16(crc16), .sector_done(sector_done),
    .ovf(ovf), .unf(unf)
  );

  sd_wr_sector_buf #(.AW(7), .CRC_EN(1'b0)) dut0 (
    .sys_clk(clk), .rst(rst), .clr(1'b0), .wr_en(wr_en0), .wr_data(wr_data0),
    .byte_rd(byte_rd0), .byte_out(byte_out0), .byte_vld(byte_vld0), .level(level0),
    .full(full0), .empty(empty0), .crc16(crc16_0), .sector_done(sector_done0),
    .ovf(ovf0), .unf(unf0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = (r[15] ^ b[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Model: pending data bytes as a queue, position within the sector byte stream
  // (0..511 data, 512 CRC hi, 513 CRC lo), and the running CRC.
  logic [7:0]  mq[$];
  int          m_pos = 0;
  logic [15:0] m_crc = 16'h0;
  logic [7:0]  m_byte = 8'h0;
  logic        m_vld = 1'b0, m_done = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk) begin
    int lvl_pre;
    if (rst || clr) begin
      mq.delete();
      m_pos = 0; m_crc = 16'h0; m_byte = 8'h0;
      m_vld = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      lvl_pre = (mq.size() + 3) / 4;
      m_vld = 1'b0;
      m_done = 1'b0;
      if (byte_rd) begin
        if (m_pos < 512) begin
          if (mq.size() == 0) m_unf = 1'b1;
          else begin
            m_byte = mq.pop_front();
            m_vld = 1'b1;
            m_crc = crc_byte(m_crc, m_byte);
            m_pos++;
          end
        end else if (m_pos == 512) begin
          m_byte = m_crc[15:8]; m_vld = 1'b1; m_pos = 513;
        end else begin
          m_byte = m_crc[7:0]; m_vld = 1'b1; m_done = 1'b1; m_crc = 16'h0; m_pos = 0;
        end
      end
      if (wr_en) begin
        if (lvl_pre == 128) m_ovf = 1'b1;
        else for (int k = 3; k >= 0; k--) mq.push_back(wr_data[8*k +: 8]);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int lv;
    if (chk_en) begin
      lv = (mq.size() + 3) / 4;
      chk("byte_vld", byte_vld, m_vld);
      chk("byte_out", byte_out, m_byte);
      chk("level", level, lv);
      chk("full", full, lv == 128);
      chk("empty", empty, lv == 0);
      chk("crc16", crc16, m_crc);
      chk("sector_done", sector_done, m_done);
      chk("ovf", ovf, m_ovf);
      chk("unf", unf, m_unf);
    end
  end

  task automatic step(input logic w, input logic [31:0] d, input logic r);
    wr_en = w; wr_data = d; byte_rd = r;
    @(posedge clk); #1;
    wr_en = 1'b0; byte_rd = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [4];
    int n_ff, n_done, n_vld;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; byte_rd = 1'b0; wr_data = '0;
    wr_en0 = 1'b0; byte_rd0 = 1'b0; wr_data0 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset values
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_crc", crc16, 0);

    // 1: one word, four bytes MSB first
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    step(1'b1, 32'h11223344, 1'b0);
    chk("t1_level1", level, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("t1_vld", byte_vld, 1);
      chk("t1_byte", byte_out, exp_b[i]);
      $display("[TB] t1 read %0d byte=%h level=%0d", i, byte_out, level);
    end
    chk("t1_level0", level, 0);
    step(1'b0, 32'h0, 1'b0);
    chk("t1_vld_drop", byte_vld, 0);
    do_clr();

    // 2: full sector of FF, CRC 7FA1
    for (int i = 0; i < 128; i++) step(1'b1, 32'hFFFFFFFF, 1'b0);
    n_ff = 0; n_done = 0;
    for (int i = 0; i < 514; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (sector_done) n_done++;
      if (i < 512 && byte_out == 8'hFF && byte_vld) n_ff++;
      if (i == 511) chk("t2_crc_running", crc16, 16'h7FA1);
      if (i == 512) chk("t2_crc_hi", byte_out, 8'h7F);
      if (i == 513) begin
        chk("t2_crc_lo", byte_out, 8'hA1);
        chk("t2_done_on_lo", sector_done, 1);
      end
    end
    chk("t2_ff_count", n_ff, 512);
    chk("t2_done_count", n_done, 1);
    $display("[TB] t2 sector served ff=%0d done=%0d", n_ff, n_done);

    // 3: overflow on 129th word; full stays blocking when a word frees the same edge
    for (int i = 0; i < 129; i++) step(1'b1, 32'h01000000 + i, 1'b0);
    chk("t3_level", level, 128);
    chk("t3_full", full, 1);
    chk("t3_ovf", ovf, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hDEADBEEF, 1'b1);
    chk("t3_full_push_pop", level, 127);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h12345678, 1'b1);
    chk("t3_push_pop_same", level, 127);
    $display("[TB] t3 level=%0d ovf=%0d", level, ovf);
    do_clr();

    // 4: underflow in data phase; CRC phase serves regardless of empty
    step(1'b0, 32'h0, 1'b1);
    chk("t4_unf_vld", byte_vld, 0);
    chk("t4_unf", unf, 1);
    do_clr();
    for (int i = 0; i < 128; i++) step(1'b1, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 512; i++) step(1'b0, 32'h0, 1'b1);
    chk("t4_empty", empty, 1);
    step(1'b0, 32'h0, 1'b1);
    chk("t4_crch_vld", byte_vld, 1);
    chk("t4_crch", byte_out, 8'h7F);
    chk("t4_crch_unf", unf, 0);
    step(1'b1, 32'hCAFEBABE, 1'b1);
    chk("t4_crcl", byte_out, 8'hA1);
    chk("t4_prefill", level, 1);
    step(1'b0, 32'h0, 1'b1);
    chk("t4_next_sector", byte_out, 8'hCA);
    $display("[TB] t4 prefill byte=%h", byte_out);

    // 5: clr mid-sector restarts at byte 0
    do_clr();
    step(1'b1, 32'hAABBCCDD, 1'b0);
    step(1'b1, 32'h01020304, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    chk("t5_5th", byte_out, 8'h01);
    do_clr();
    chk("t5_level", level, 0);
    chk("t5_empty", empty, 1);
    chk("t5_crc", crc16, 0);
    step(1'b1, 32'h55667788, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("t5_bi0", byte_out, 8'h55);
    $display("[TB] t5 after clr byte=%h", byte_out);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 600; i++) step((i % 3) != 2, (i * 32'h01010101) ^ 32'h5A, (i % 5) < 3);
    for (int i = 0; i < 700; i++) step((i % 7) == 0, 32'h9E3779B9 + i, 1'b1);
    $display("[TB] mixed traffic done level=%0d", level);

    // 6: CRC disabled instance
    for (int i = 0; i < 128; i++) begin
      wr_en0 = 1'b1; wr_data0 = 32'h0;
      @(posedge clk); #1;
    end
    wr_en0 = 1'b0;
    n_vld = 0; n_done = 0;
    byte_rd0 = 1'b1;
    for (int i = 0; i < 514; i++) begin
      @(posedge clk); #1;
      if (byte_vld0) n_vld++;
      if (sector_done0) begin
        n_done++;
        chk("t6_done_pos", i, 511);
      end
    end
    byte_rd0 = 1'b0;
    chk("t6_bytes", n_vld, 512);
    chk("t6_done_count", n_done, 1);
    chk("t6_unf", unf0, 1);
    chk("t6_crc_zero", crc16_0, 0);
    $display("[TB] t6 bytes=%0d done=%0d", n_vld, n_done);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
